ldpc_layer_scheduler: RTL and testbench
=======================================

# ldpc_layer_scheduler

Sequencing controller for the LDPC decoder's layered schedule. It drives the enable and synchronous-reset inputs of the external memory address generator. For each layer it sweeps LAYER_LEN addresses, drains the datapath pipeline, then advances layers and iterations. It stops on syndrome convergence, MAX_ITER exhaustion or abort, and reports iteration count and convergence status.

## Interface
- ADDR_WIDTH, 8: width of the driven address generator; LAYER_LEN must be ≤ 2^ADDR_WIDTH
- NUM_LAYERS, 4: layers per iteration, ≥ 1
- LAYER_LEN, 16: addresses swept per layer, ≥ 1
- PIPE_LAT, 3: drain cycles after each sweep, ≥ 0
- MAX_ITER, 10: iteration limit, ≥ 1
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  begin decode; honoured only in IDLE
- abort  in  1  synchronous; return to IDLE next edge, no done pulse
- syndrome_ok  in  1  parity check passed; sampled only in CHECK
- ag_en  out  1  address generator enable
- ag_reset  out  1  address generator synchronous reload (meaningful only with ag_en=1)
- addr_valid  out  1  address generator output is a valid sweep address this cycle
- layer_idx  out  max(1,$clog2(NUM_LAYERS))  current layer
- iter_idx  out  $clog2(MAX_ITER+1)  current iteration, 0-based
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse
- converged  out  1  final syndrome_ok; held until next accepted start
- iter_count  out  $clog2(MAX_ITER+1)  iterations executed; held until next accepted start

## Operation
- States: IDLE, LOAD, SWEEP, DRAIN, CHECK, DONE.
- IDLE: all outputs 0 except held converged/iter_count. On start: clear layer_idx, iter_idx, converged and iter_count, then go to LOAD.
- LOAD, 1 cycle: ag_en=1, ag_reset=1. Go to SWEEP.
- SWEEP, LAYER_LEN cycles: ag_en=1, ag_reset=0, addr_valid=1. Go to DRAIN, or skip to layer-end if PIPE_LAT=0.
- DRAIN, PIPE_LAT cycles: ag_en=0.
- Layer-end: if layer_idx < NUM_LAYERS-1, increment layer_idx and go to LOAD; otherwise go to CHECK.
- CHECK, 1 cycle:
  - syndrome_ok=1: converged←1, go to DONE.
  - Else if iter_idx = MAX_ITER-1: converged←0, go to DONE.
  - Else: iter_idx++, layer_idx←0, go to LOAD.
- DONE, 1 cycle: done=1, iter_count←iter_idx+1. Go to IDLE.
- abort in any non-IDLE state: go to IDLE next edge. No done pulse; converged and iter_count stay 0.
- abort has priority over every other transition. start outside IDLE is ignored.
- A single down-counter, loaded on state entry, times SWEEP and DRAIN. No arithmetic wraps; all counters saturate at their terminal values.

## Timing
- Reset value of every output is 0.
- Call the cycle after start is sampled in IDLE "cycle 1"; it is LOAD.
- The address generator output equals 0 during the first SWEEP cycle and k during SWEEP cycle k+1. addr_valid is aligned with it.
- One layer takes 1+LAYER_LEN+PIPE_LAT cycles. One iteration takes NUM_LAYERS·(1+LAYER_LEN+PIPE_LAT)+1 cycles.
- done asserts in the cycle after the final CHECK. busy falls in the cycle after done.
- start asserted in the same cycle as done is ignored. The earliest accepted start is the first IDLE cycle.
- Reset asserted mid-decode: outputs go to 0 asynchronously and the FSM is in IDLE on release.

## Structure
- Shared package ldpc_sched_pkg holds:
  - the state enum (6 states, 3-bit encoding)
  - width helper constants for layer_idx and iter_idx
- Natural sub-module: sched_cycle_counter, a loadable down-counter with a terminal-count flag, shared by SWEEP and DRAIN.
- The address generator itself is instantiated outside this block.

## Test plan
Bench parameters for all scenarios: NUM_LAYERS=2, LAYER_LEN=4, PIPE_LAT=2, MAX_ITER=3.
- Immediate convergence: start with syndrome_ok=1 → addr_valid high in cycles 2–5 and 9–12; CHECK at cycle 15; done at cycle 16; converged=1, iter_count=1.
- No convergence: start with syndrome_ok=0 throughout → layer_idx/iter_idx step correctly; done at cycle 46; converged=0, iter_count=3.
- Convergence on 2nd iteration: syndrome_ok=1 only at cycle 30 → done at cycle 31; iter_count=2, converged=1.
- Abort during SWEEP at cycle 10 → IDLE at cycle 11; no done; ag_en=0; then start → clean rerun matching scenario 1.
- Async reset at cycle 20, then start while busy → outputs go to 0 without a clock edge; start during busy changes nothing.
- PIPE_LAT=0 variant → layer length 5 cycles; done at cycle 12 on immediate convergence.

Source files
------------

// File: rtl/ldpc_sched_pkg.sv
// Shared state encoding and width helpers for the LDPC layered-schedule controller.
package ldpc_sched_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_e;

    function automatic int unsigned layer_idx_w(input int unsigned num_layers);
        return (num_layers <= 1) ? 1 : $clog2(num_layers);
    endfunction

    function automatic int unsigned iter_idx_w(input int unsigned max_iter);
        return (max_iter < 1) ? 1 : $clog2(max_iter + 1);
    endfunction

    // The phase timer must hold LAYER_LEN-1 (bounded by the address width) and PIPE_LAT-1.
    function automatic int unsigned cnt_w(input int unsigned addr_w, input int unsigned pipe_lat);
        int unsigned w;
        w = (addr_w < 1) ? 1 : addr_w;
        if (pipe_lat > 1 && $clog2(pipe_lat) > w) begin
            w = $clog2(pipe_lat);
        end
        return w;
    endfunction

endpackage

// File: rtl/sched_cycle_counter.sv
// Loadable down-counter with terminal-count flag; times both the SWEEP and DRAIN phases.
module sched_cycle_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/ldpc_layer_scheduler.sv
// Layered-schedule sequencer for the LDPC decoder: drives the external address generator
// through LOAD/SWEEP/DRAIN per layer and CHECK per iteration.
//   state | meaning
//   IDLE  | waiting for start, results held
//   LOAD  | address generator reload (ag_en, ag_reset)
//   SWEEP | LAYER_LEN valid addresses
//   DRAIN | PIPE_LAT cycles for the datapath pipeline to empty
//   CHECK | sample syndrome, decide converge / give up / next iteration
//   DONE  | one-cycle done pulse, iter_count published
module ldpc_layer_scheduler
    import ldpc_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned LAYER_LEN  = 16,
    parameter int unsigned PIPE_LAT   = 3,
    parameter int unsigned MAX_ITER   = 10,
    localparam int unsigned LAYER_W   = layer_idx_w(NUM_LAYERS),
    localparam int unsigned ITER_W    = iter_idx_w(MAX_ITER)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               syndrome_ok_i,
    output logic               ag_en_o,
    output logic               ag_reset_o,
    output logic               addr_valid_o,
    output logic [LAYER_W-1:0] layer_idx_o,
    output logic [ITER_W-1:0]  iter_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               converged_o,
    output logic [ITER_W-1:0]  iter_count_o
);

    localparam int unsigned        CNT_W      = cnt_w(ADDR_WIDTH, PIPE_LAT);
    localparam logic [CNT_W-1:0]   SWEEP_LOAD = CNT_W'(LAYER_LEN - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LOAD = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [ITER_W-1:0]  LAST_ITER  = ITER_W'(MAX_ITER - 1);

    sched_state_e       state_q;
    sched_state_e       state_d;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_en;
    logic               cnt_tc;
    logic               last_layer;

    logic               ag_en_q;
    logic               ag_reset_q;
    logic               addr_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               converged_q;
    logic [LAYER_W-1:0] layer_q;
    logic [ITER_W-1:0]  iter_q;
    logic [ITER_W-1:0]  iter_count_q;

    assign last_layer = (layer_q == LAST_LAYER);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SWEEP;
            ST_SWEEP: begin
                if (cnt_tc) begin
                    if (PIPE_LAT > 0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = last_layer ? ST_CHECK : ST_LOAD;
                    end
                end
            end
            ST_DRAIN: if (cnt_tc) state_d = last_layer ? ST_CHECK : ST_LOAD;
            ST_CHECK: state_d = (syndrome_ok_i || iter_q == LAST_ITER) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    // Every phase change reloads the timer; only SWEEP and DRAIN entries care about the value.
    assign cnt_load     = (state_d != state_q);
    assign cnt_load_val = (state_d == ST_DRAIN) ? DRAIN_LOAD : SWEEP_LOAD;
    assign cnt_en       = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);

    sched_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .tc_o       (cnt_tc)
    );

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            ag_en_q      <= 1'b0;
            ag_reset_q   <= 1'b0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            converged_q  <= 1'b0;
            layer_q      <= '0;
            iter_q       <= '0;
            iter_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ag_en_q      <= (state_d == ST_LOAD) || (state_d == ST_SWEEP);
            ag_reset_q   <= (state_d == ST_LOAD);
            addr_valid_q <= (state_d == ST_SWEEP);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);

            if (state_d == ST_IDLE) begin
                layer_q <= '0;
                iter_q  <= '0;
                if (abort_i && state_q != ST_IDLE) begin
                    converged_q  <= 1'b0;
                    iter_count_q <= '0;
                end
            end else if (state_q == ST_IDLE) begin
                layer_q      <= '0;
                iter_q       <= '0;
                converged_q  <= 1'b0;
                iter_count_q <= '0;
            end else if (state_q == ST_CHECK) begin
                if (state_d == ST_DONE) begin
                    converged_q  <= syndrome_ok_i;
                    iter_count_q <= iter_q + 1'b1;
                end else begin
                    iter_q  <= iter_q + 1'b1;
                    layer_q <= '0;
                end
            end else if (state_d == ST_LOAD) begin
                layer_q <= layer_q + 1'b1;
            end
        end
    end

    assign ag_en_o      = ag_en_q;
    assign ag_reset_o   = ag_reset_q;
    assign addr_valid_o = addr_valid_q;
    assign layer_idx_o  = layer_q;
    assign iter_idx_o   = iter_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign converged_o  = converged_q;
    assign iter_count_o = iter_count_q;

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
// Scoreboard bench for ldpc_layer_scheduler: expected LOAD/SWEEP/DONE events come from
// cycle arithmetic over the layered schedule; monitors pop and compare as the DUT emits them.
module tb_ldpc_layer_scheduler;
    import ldpc_sched_pkg::*;

    localparam int unsigned AW  = 8;
    localparam int unsigned NL  = 2;
    localparam int unsigned LEN = 4;
    localparam int unsigned PL  = 2;
    localparam int unsigned MI  = 3;
    localparam int unsigned LW  = layer_idx_w(NL);
    localparam int unsigned IW  = iter_idx_w(MI);

    logic clk = 1'b0;
    logic rst_n;
    logic start_m, start_z, abort, synd_m, synd_z;

    logic          ag_en, ag_reset, addr_valid, busy, done, converged;
    logic [LW-1:0] layer_idx;
    logic [IW-1:0] iter_idx, iter_count;

    logic          ag_en_z, ag_reset_z, addr_valid_z, busy_z, done_z, converged_z;
    logic [LW-1:0] layer_idx_z;
    logic [IW-1:0] iter_idx_z, iter_count_z;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ldpc_layer_scheduler #(
        .ADDR_WIDTH(AW), .NUM_LAYERS(NL), .LAYER_LEN(LEN), .PIPE_LAT(PL), .MAX_ITER(MI)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_m), .abort_i(abort), .syndrome_ok_i(synd_m),
        .ag_en_o(ag_en), .ag_reset_o(ag_reset), .addr_valid_o(addr_valid),
        .layer_idx_o(layer_idx), .iter_idx_o(iter_idx), .busy_o(busy), .done_o(done),
        .converged_o(converged), .iter_count_o(iter_count)
    );

    ldpc_layer_scheduler #(
        .ADDR_WIDTH(AW), .NUM_LAYERS(NL), .LAYER_LEN(LEN), .PIPE_LAT(0), .MAX_ITER(MI)
    ) dut_z (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_z), .abort_i(abort), .syndrome_ok_i(synd_z),
        .ag_en_o(ag_en_z), .ag_reset_o(ag_reset_z), .addr_valid_o(addr_valid_z),
        .layer_idx_o(layer_idx_z), .iter_idx_o(iter_idx_z), .busy_o(busy_z), .done_o(done_z),
        .converged_o(converged_z), .iter_count_o(iter_count_z)
    );

    typedef struct { int cyc; int layer; int iter; } ev_t;
    typedef struct { int cyc; int conv; int cnt; int nav; } dn_t;

    ev_t q_load[$];
    ev_t q_av[$];
    dn_t q_done[$];
    dn_t q_done_z[$];

    int n_pass = 0;
    int n_chk  = 0;
    int nav_z  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin : mon_main
        ev_t e;
        dn_t d;
        if (ag_en && ag_reset) begin
            if (q_load.size() == 0) check("load_unexpected", q_load.size(), 1);
            else begin
                e = q_load.pop_front();
                check("load_cycle", cyc, e.cyc);
                check("load_layer", 32'(layer_idx), e.layer);
                check("load_iter", 32'(iter_idx), e.iter);
            end
        end
        if (addr_valid) begin
            if (q_av.size() == 0) check("sweep_unexpected", q_av.size(), 1);
            else begin
                e = q_av.pop_front();
                check("sweep_cycle", cyc, e.cyc);
                check("sweep_layer", 32'(layer_idx), e.layer);
                check("sweep_iter", 32'(iter_idx), e.iter);
                check("sweep_ag_en_reset", 32'({ag_en, ag_reset}), 2);
            end
        end
        if (ag_en && !ag_reset && !addr_valid) check("ag_en_stray", 32'(ag_en), 0);
        if (done) begin
            if (q_done.size() == 0) check("done_unexpected", q_done.size(), 1);
            else begin
                d = q_done.pop_front();
                check("done_cycle", cyc, d.cyc);
                check("done_converged", 32'(converged), d.conv);
                check("done_iter_count", 32'(iter_count), d.cnt);
                check("done_busy", 32'(busy), 1);
            end
        end
    end

    always @(negedge clk) begin : mon_z
        dn_t d;
        if (addr_valid_z) nav_z++;
        if (ag_reset_z) check("z_load_ag_en", 32'(ag_en_z), 1);
        if (done_z) begin
            if (q_done_z.size() == 0) check("z_done_unexpected", q_done_z.size(), 1);
            else begin
                d = q_done_z.pop_front();
                check("z_done_cycle", cyc, d.cyc);
                check("z_converged", 32'(converged_z), d.conv);
                check("z_iter_count", 32'(iter_count_z), d.cnt);
                check("z_sweep_addrs", nav_z, d.nav);
                check("z_final_iter_idx", 32'(iter_idx_z), d.cnt - 1);
                check("z_final_layer_idx", 32'(layer_idx_z), NL - 1);
            end
            nav_z = 0;
        end
    end

    // kill_kind: 0 none, 1 abort at cycle kill_at, 2 async reset during cycle kill_at.
    task automatic run_decode(input bit z, input int conv_iter, input int kill_at,
                              input int kill_kind, input bit noise);
        int  pl, lay, itc, n_iter, done_r, end_r, s, lr;
        bit  st, sy;
        ev_t e;
        dn_t d;
        pl     = z ? 0 : PL;
        lay    = 1 + LEN + pl;
        itc    = NL * lay + 1;
        n_iter = (conv_iter >= 0) ? conv_iter + 1 : MI;
        done_r = n_iter * itc + 1;
        end_r  = (kill_kind != 0) ? kill_at + 1 : done_r + 1;

        @(negedge clk);
        s = cyc;
        for (int it = 0; it < n_iter; it++) begin
            for (int l = 0; l < NL; l++) begin
                lr = 1 + it * itc + l * lay;
                if (!z && (kill_kind == 0 || lr <= kill_at)) begin
                    e.cyc = s + lr; e.layer = l; e.iter = it;
                    q_load.push_back(e);
                end
                for (int k = 0; k < LEN; k++) begin
                    if (!z && (kill_kind == 0 || lr + 1 + k <= kill_at)) begin
                        e.cyc = s + lr + 1 + k; e.layer = l; e.iter = it;
                        q_av.push_back(e);
                    end
                end
            end
        end
        d.cyc = s + done_r; d.conv = (conv_iter >= 0) ? 1 : 0;
        d.cnt = n_iter;     d.nav  = n_iter * NL * LEN;
        if (z) q_done_z.push_back(d);
        else if (kill_kind == 0) q_done.push_back(d);

        if (z) start_z = 1'b1; else start_m = 1'b1;
        for (int r = 1; r <= end_r; r++) begin
            @(negedge clk);
            st = noise && r >= 2 && r < end_r && ($urandom_range(0, 3) == 0);
            if (r % itc == 0) sy = (conv_iter >= 0) && (r == n_iter * itc);
            else              sy = noise && ($urandom_range(0, 1) == 1);
            if (z) begin start_z = st; synd_z = sy; end
            else   begin start_m = st; synd_m = sy; end
            abort = (kill_kind == 1) && (r == kill_at);
            if (kill_kind == 2 && r == kill_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_ag_en", 32'(ag_en), 0);
                check("async_addr_valid", 32'(addr_valid), 0);
                check("async_busy", 32'(busy), 0);
                check("async_layer_iter", 32'({layer_idx, iter_idx}), 0);
            end
        end

        abort = 1'b0;
        if (kill_kind == 0) begin
            if (z) begin
                check("z_busy_after_done", 32'(busy_z), 0);
                check("z_converged_held", 32'(converged_z), d.conv);
                check("z_iter_count_held", 32'(iter_count_z), d.cnt);
            end else begin
                check("busy_after_done", 32'(busy), 0);
                check("converged_held", 32'(converged), d.conv);
                check("iter_count_held", 32'(iter_count), d.cnt);
            end
        end else begin
            check("kill_busy", 32'(busy), 0);
            check("kill_ag_en", 32'(ag_en), 0);
            check("kill_done", 32'(done), 0);
            check("kill_converged", 32'(converged), 0);
            check("kill_iter_count", 32'(iter_count), 0);
            if (kill_kind == 2) rst_n = 1'b1;
        end
        synd_m = 1'b0;
        synd_z = 1'b0;
    endtask

    initial begin
        int ci, ka, kk, dr;
        rst_n = 1'b0; start_m = 1'b0; start_z = 1'b0; abort = 1'b0; synd_m = 1'b0; synd_z = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ag_en", 32'(ag_en), 0);
        check("rst_ag_reset", 32'(ag_reset), 0);
        check("rst_addr_valid", 32'(addr_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_converged", 32'(converged), 0);
        check("rst_idx", 32'({layer_idx, iter_idx}), 0);
        check("rst_iter_count", 32'(iter_count), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        run_decode(0,  0, -1, 0, 0);
        run_decode(0, -1, -1, 0, 0);
        run_decode(0,  1, -1, 0, 0);
        run_decode(0,  0, 10, 1, 0);
        run_decode(0,  0, -1, 0, 0);
        run_decode(0, -1, 20, 2, 0);
        run_decode(0,  1, -1, 0, 0);
        run_decode(1,  0, -1, 0, 0);
        run_decode(1, -1, -1, 0, 0);

        for (int n = 0; n < 16; n++) begin
            ci = $urandom_range(0, MI);
            if (ci == MI) ci = -1;
            dr = ((ci >= 0) ? ci + 1 : MI) * (NL * (1 + LEN + PL) + 1) + 1;
            kk = 0;
            ka = -1;
            if ($urandom_range(0, 3) == 0) begin
                kk = $urandom_range(1, 2);
                ka = $urandom_range(1, dr - 1);
            end
            run_decode(0, ci, ka, kk, 1);
        end

        repeat (3) @(negedge clk);
        check("q_load_drained", q_load.size(), 0);
        check("q_sweep_drained", q_av.size(), 0);
        check("q_done_drained", q_done.size(), 0);
        check("q_done_z_drained", q_done_z.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
